muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit. Sits beside the single-cycle ALU in the execute stage.
- The ALU covers add/sub/shift/compare/logic in zero cycles. This block covers the eight M-extension ops over multiple cycles.
- The control unit issues requests via a start/busy/done handshake and stalls the pipeline while busy.

---
 rtl/muldiv_unit.sv | 194 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Define MULDIV_FAST_MUL_EN to give the multiply ops a single combinational path.
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] dataa,
    input  logic [XLEN-1:0] datab,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIN,
        FMUL
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                ld_q, ld_d;
    logic [2:0]          op_q, op_d;
    logic [XLEN-1:0]     a_q, a_d;
    logic [XLEN-1:0]     b_q, b_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic [XLEN-1:0]     dvs_q, dvs_d;
    logic                done_q, done_d;
    logic [XLEN-1:0]     res_q, res_d;

    logic                accept;
    logic                is_div;
    logic                a_sgn, b_sgn;
    logic                sa, sb;
    logic [XLEN-1:0]     mag_a, mag_b;
    logic [XLEN:0]       msum;
    logic [2*XLEN-1:0]   mul_nx;
    logic [XLEN:0]       drem;
    logic                dge;
    logic [XLEN-1:0]     dsub;
    logic [2*XLEN-1:0]   div_nx;
    logic [2*XLEN-1:0]   acc_nx;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     quo, rem;
    logic                div0;
    logic [XLEN-1:0]     fin_res;

    assign is_div = op_q[2];
    assign a_sgn  = (op_q == 3'b001) || (op_q == 3'b010) ||
                    (op_q == 3'b100) || (op_q == 3'b110);
    assign b_sgn  = (op_q == 3'b001) || (op_q == 3'b100) ||
                    (op_q == 3'b110);
    assign sa     = a_sgn & a_q[XLEN-1];
    assign sb     = b_sgn & b_q[XLEN-1];
    assign mag_a  = sa ? -a_q : a_q;
    assign mag_b  = sb ? -b_q : b_q;

    // Shift-add step: high half accumulates, multiplier drains from the low half.
    assign msum   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, dvs_q} : '0);
    assign mul_nx = {msum, acc_q[XLEN-1:1]};

    // Restoring step: remainder in the high half, quotient bits enter at bit 0.
    assign drem   = acc_q[2*XLEN-1:XLEN-1];
    assign dge    = drem >= {1'b0, dvs_q};
    assign dsub   = drem[XLEN-1:0] - dvs_q;
    assign div_nx = dge ? {dsub, acc_q[XLEN-2:0], 1'b1}
                        : {drem[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    assign acc_nx = is_div ? div_nx : mul_nx;

    assign prod = (sa ^ sb) ? -acc_nx : acc_nx;
    assign quo  = acc_nx[XLEN-1:0];
    assign rem  = acc_nx[2*XLEN-1:XLEN];
    assign div0 = (b_q == '0);

    always_comb begin
        fin_res = '0;
        case (op_q)
            3'b000: fin_res = prod[XLEN-1:0];
            3'b001,
            3'b010,
            3'b011: fin_res = prod[2*XLEN-1:XLEN];
            3'b100,
            3'b101: fin_res = div0 ? '1 : ((sa ^ sb) ? -quo : quo);
            default: fin_res = div0 ? a_q : (sa ? -rem : rem);
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fprod;
    logic [2*XLEN-1:0] fsgn;
    logic [XLEN-1:0]   fres;

    assign fprod = {{XLEN{1'b0}}, mag_a} * {{XLEN{1'b0}}, mag_b};
    assign fsgn  = (sa ^ sb) ? -fprod : fprod;
    assign fres  = (op_q[1:0] == 2'b00) ? fsgn[XLEN-1:0]
                                        : fsgn[2*XLEN-1:XLEN];
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ld_d    = ld_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        dvs_d   = dvs_q;
        done_d  = 1'b0;
        res_d   = res_q;
        accept  = 1'b0;

        unique case (state_q)
            IDLE: accept = start;
            CALC: begin
                if (ld_q) begin
                    ld_d  = 1'b0;
                    acc_d = {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
                    dvs_d = is_div ? mag_b : mag_a;
                end else begin
                    acc_d = acc_nx;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(XLEN - 1)) begin
                        state_d = FIN;
                        done_d  = 1'b1;
                        res_d   = fin_res;
                    end
                end
            end
            FIN: begin
                accept  = start;
                state_d = IDLE;
            end
`ifdef MULDIV_FAST_MUL_EN
            FMUL: begin
                state_d = FIN;
                done_d  = 1'b1;
                res_d   = fres;
            end
`endif
            default: state_d = IDLE;
        endcase

        if (accept) begin
            op_d    = op;
            a_d     = dataa;
            b_d     = datab;
            cnt_d   = '0;
            ld_d    = 1'b1;
            state_d = CALC;
`ifdef MULDIV_FAST_MUL_EN
            if (!op[2]) begin
                state_d = FMUL;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            ld_q    <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            dvs_q   <= '0;
            done_q  <= 1'b0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ld_q    <= ld_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            dvs_q   <= dvs_d;
            done_q  <= done_d;
            res_q   <= res_d;
        end
    end

    assign busy   = (state_q == CALC);
    assign done   = done_q;
    assign result = res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed checks of muldiv_unit results, latency and control.
// Honours MULDIV_FAST_MUL_EN for multiply latency expectations.
module tb_muldiv_unit;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [2:0]  op;
    logic [31:0] dataa;
    logic [31:0] datab;
    logic        busy;
    logic        done;
    logic [31:0] result;

    int n_cmp = 0;
    int n_bad = 0;

    muldiv_unit #(
        .XLEN  (32),
        .CNT_W (6)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .op     (op),
        .dataa  (dataa),
        .datab  (datab),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b);
        @(negedge clk);
        op    = o;
        dataa = a;
        datab = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    function automatic int lat_of(input logic [2:0] o);
        return (FAST && !o[2]) ? 1 : 33;
    endfunction

    // Entered 1 time unit after edge E<already>; done is due after E<lat>.
    task automatic expect_done(input string tag, input logic [2:0] o,
                               input int already, input logic [31:0] exp);
        int lat;
        lat = lat_of(o);
        repeat (lat - 1 - already) @(posedge clk);
        #1;
        chk({tag, ".pre_done"}, 32'(done), 32'd0);
        chk({tag, ".pre_busy"}, 32'(busy), 32'(lat > 1));
        @(posedge clk);
        #1;
        chk({tag, ".done"}, 32'(done), 32'd1);
        chk({tag, ".busy"}, 32'(busy), 32'd0);
        chk({tag, ".result"}, result, exp);
        @(posedge clk);
        #1;
        chk({tag, ".done_drop"}, 32'(done), 32'd0);
    endtask

    task automatic run(input string tag, input logic [2:0] o,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
        issue(o, a, b);
        expect_done(tag, o, 0, exp);
    endtask

    initial begin
        int n;
        int seen;
        rst   = 1'b1;
        start = 1'b0;
        op    = 3'b000;
        dataa = '0;
        datab = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.busy", 32'(busy), 32'd0);
        chk("reset.done", 32'(done), 32'd0);
        chk("reset.result", result, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run("mul", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
        run("mulh", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000);
        run("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("mulhu", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run("div", 3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA);
        run("rem", 3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE);
        run("divu", 3'b101, 32'd20, 32'd3, 32'd6);
        run("remu", 3'b111, 32'd20, 32'd3, 32'd2);
        run("div0", 3'b100, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        run("rem0", 3'b110, 32'h1234_5678, 32'd0, 32'h1234_5678);
        run("div0neg", 3'b100, 32'hFFFF_FFEC, 32'd0, 32'hFFFF_FFFF);
        run("remu0", 3'b111, 32'hFFFF_FFEC, 32'd0, 32'hFFFF_FFEC);
        run("divovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run("removf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        issue(3'b101, 32'd20, 32'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        op    = 3'b000;
        dataa = 32'd5;
        datab = 32'd9;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        expect_done("midstart", 3'b101, 5, 32'd6);

        issue(3'b111, 32'd20, 32'd3);
        repeat (32) @(posedge clk);
        @(posedge clk);
        #1;
        chk("b2b.first_done", 32'(done), 32'd1);
        chk("b2b.first_result", result, 32'd2);
        @(negedge clk);
        op    = 3'b101;
        dataa = 32'd100;
        datab = 32'd7;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b.busy", 32'(busy), 32'd1);
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b.gap", 32'(n), 32'd33);
        chk("b2b.result", result, 32'd14);

        issue(3'b100, 32'hFFFF_FFEC, 32'd3);
        repeat (11) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.done", 32'(done), 32'd0);
        chk("abort.result", result, 32'd0);
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("abort.no_done", 32'(seen), 32'd0);

        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        op    = 3'b000;
        dataa = 32'd2;
        datab = 32'd3;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        start = 1'b0;
        chk("rststart.busy0", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("rststart.busy1", 32'(busy), 32'd0);
        seen = 0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("rststart.no_done", 32'(seen), 32'd0);
        chk("rststart.result", result, 32'd0);

        run("mul6x7", 3'b000, 32'd6, 32'd7, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
